// File: rtl/clut_cache_pkg.sv
// Shared types, widths and elaboration helpers for the multi-port CLUT cache.
package clut_cache_pkg;

  localparam int COLOR_W     = 16;
  localparam int FILL_BEAT_W = 32;

  typedef enum logic [1:0] {IDLE, REQ, FILL} fillStateT;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Each 32-bit fill beat carries two colours.
  function automatic int beats_per_blk(input int blkColors);
    return blkColors / 2;
  endfunction

endpackage

// File: rtl/clut_cache_ram.sv
// Palette word storage: one write port, NUM_PORTS registered read ports built
// from replicated banks so each bank is a simple dual-port block RAM.
module clut_cache_ram
  import clut_cache_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 7
) (
  input  logic                            clk,
  input  logic                            i_rst,
  input  logic                            wrEn,
  input  logic [ADDR_W-1:0]               wrAddr,
  input  logic [FILL_BEAT_W-1:0]          wrData,
  input  logic [NUM_PORTS*ADDR_W-1:0]     rdAddr,
  output logic [NUM_PORTS*FILL_BEAT_W-1:0] rdData
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_bank
    logic [FILL_BEAT_W-1:0] mem [2**ADDR_W];
    logic [FILL_BEAT_W-1:0] rdQ;

    // NOTE: the array has no reset so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
      if (wrEn) mem[wrAddr] <= wrData;
    end

    // NOTE: non-blocking read and write on the same edge return the old word on a collision.
    always_ff @(posedge clk) begin
      if (i_rst) rdQ <= '0;
      else       rdQ <= mem[rdAddr[p*ADDR_W +: ADDR_W]];
    end

    assign rdData[p*FILL_BEAT_W +: FILL_BEAT_W] = rdQ;
  end

endmodule

// File: rtl/clut_cache_mp.sv
// Multi-port texture CLUT cache with its own block-fill FSM towards the VRAM arbiter.
// Optional hit/miss statistics counters are enabled by defining CLUT_CACHE_STATS_EN.
module clut_cache_mp
  import clut_cache_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int IDX_W      = 8,
  parameter int BLK_COLORS = 16,
  parameter int FILL_ID_W  = 4
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic [14:0]                  i_clut_id,
  input  logic [NUM_PORTS-1:0]         i_req,
  input  logic [NUM_PORTS*IDX_W-1:0]   i_idx,
  output logic [NUM_PORTS-1:0]         o_hit,
  output logic [NUM_PORTS-1:0]         o_miss,
  output logic [NUM_PORTS*COLOR_W-1:0] o_color,
  output logic                         o_fill_req,
  output logic [FILL_ID_W-1:0]         o_fill_blk,
  output logic [14:0]                  o_fill_clut,
  input  logic                         i_fill_ack,
  input  logic                         i_fill_valid,
  input  logic [FILL_BEAT_W-1:0]       i_fill_data,
`ifdef CLUT_CACHE_STATS_EN
  output logic [15:0]                  o_hit_cnt,
  output logic [15:0]                  o_miss_cnt,
`endif
  output logic                         o_busy
);

  localparam int BEATS     = beats_per_blk(BLK_COLORS);
  localparam int BEAT_BITS = clog2(BEATS);
  localparam int CNT_W     = (BEAT_BITS > 0) ? BEAT_BITS : 1;
  localparam int ADDR_W    = IDX_W - 1;
  localparam int NUM_BLKS  = 2**FILL_ID_W;

  fillStateT                  state, nextState;
  logic [NUM_BLKS-1:0]        validQ;
  logic [14:0]                clutIdQ;
  logic                       clutChange;
  logic                       aborted;
  logic [CNT_W-1:0]           cnt;
  logic                       lastBeat;
  logic [FILL_ID_W-1:0]       selBlk;
  logic [FILL_ID_W-1:0]       blk [NUM_PORTS];
  logic [NUM_PORTS*ADDR_W-1:0] rdAddr;
  logic [NUM_PORTS*FILL_BEAT_W-1:0] rdData;
  logic [NUM_PORTS-1:0]       halfSel;
  logic                       wrEn;
  logic [ADDR_W-1:0]          wrAddr;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    o_hit  = '0;
    o_miss = '0;
    rdAddr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      blk[p]   = i_idx[p*IDX_W + IDX_W - FILL_ID_W +: FILL_ID_W];
      o_hit[p]  = i_req[p] &  validQ[blk[p]];
      o_miss[p] = i_req[p] & ~validQ[blk[p]];
      rdAddr[p*ADDR_W +: ADDR_W] = i_idx[p*IDX_W + 1 +: ADDR_W];
    end
  end

  // Descending scan so the lowest missing port wins.
  always_comb begin
    selBlk = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (o_miss[p]) selBlk = blk[p];
    end
  end

  assign clutChange = (i_clut_id != clutIdQ);
  assign lastBeat   = (cnt == CNT_W'(BEATS - 1));

  always_ff @(posedge clk) begin
    clutIdQ <= i_clut_id;
  end

  always_ff @(posedge clk) begin
    if (i_rst) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (|o_miss)                    nextState = REQ;
      REQ:     if (i_fill_ack)                 nextState = FILL;
      FILL:    if (i_fill_valid && lastBeat)   nextState = IDLE;
      default:                                 nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_fill_blk  <= '0;
      o_fill_clut <= '0;
      cnt         <= '0;
      aborted     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|o_miss) begin
          o_fill_blk  <= selBlk;
          o_fill_clut <= i_clut_id;
        end
        REQ:  if (i_fill_ack)   cnt <= '0;
        FILL: if (i_fill_valid) cnt <= cnt + 1'b1;
        default: ;
      endcase
      if (nextState == IDLE)                  aborted <= 1'b0;
      else if (clutChange && state != IDLE)   aborted <= 1'b1;
    end
  end

  // A palette change on the same edge as the last beat still wins over the set.
  always_ff @(posedge clk) begin
    if (i_rst || clutChange)
      validQ <= '0;
    else if (state == FILL && i_fill_valid && lastBeat && !aborted)
      validQ[o_fill_blk] <= 1'b1;
  end

  assign wrEn   = (state == FILL) && i_fill_valid;
  assign wrAddr = (ADDR_W'(o_fill_blk) << BEAT_BITS) | ADDR_W'(cnt);

  clut_cache_ram #(
    .NUM_PORTS (NUM_PORTS),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk    (clk),
    .i_rst  (i_rst),
    .wrEn   (wrEn),
    .wrAddr (wrAddr),
    .wrData (i_fill_data),
    .rdAddr (rdAddr),
    .rdData (rdData)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      halfSel <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) halfSel[p] <= i_idx[p*IDX_W];
    end
  end

  always_comb begin
    o_color = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      o_color[p*COLOR_W +: COLOR_W] = halfSel[p] ? rdData[p*FILL_BEAT_W + COLOR_W +: COLOR_W]
                                                 : rdData[p*FILL_BEAT_W +: COLOR_W];
    end
  end

  assign o_fill_req = (state == REQ);
  assign o_busy     = (state != IDLE);

`ifdef CLUT_CACHE_STATS_EN
  logic [16:0] hitSum, missSum;

  assign hitSum  = {1'b0, o_hit_cnt}  + 17'($countones(o_hit));
  assign missSum = {1'b0, o_miss_cnt} + 17'($countones(o_miss));

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
    end else begin
      o_hit_cnt  <= (hitSum  > 17'h0FFFF) ? 16'hFFFF : hitSum[15:0];
      o_miss_cnt <= (missSum > 17'h0FFFF) ? 16'hFFFF : missSum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_clut_cache_mp.sv
// Directed self-checking bench for clut_cache_mp (2 ports, 8-bit index, 16-colour blocks).
module tb_clut_cache_mp;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [14:0] i_clut_id;
  logic [1:0]  i_req;
  logic [15:0] i_idx;
  logic [1:0]  o_hit, o_miss;
  logic [31:0] o_color;
  logic        o_fill_req;
  logic [3:0]  o_fill_blk;
  logic [14:0] o_fill_clut;
  logic        i_fill_ack, i_fill_valid;
  logic [31:0] i_fill_data;
  logic        o_busy;
`ifdef CLUT_CACHE_STATS_EN
  logic [15:0] o_hit_cnt, o_miss_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  clut_cache_mp dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_clut_id    (i_clut_id),
    .i_req        (i_req),
    .i_idx        (i_idx),
    .o_hit        (o_hit),
    .o_miss       (o_miss),
    .o_color      (o_color),
    .o_fill_req   (o_fill_req),
    .o_fill_blk   (o_fill_blk),
    .o_fill_clut  (o_fill_clut),
    .i_fill_ack   (i_fill_ack),
    .i_fill_valid (i_fill_valid),
    .i_fill_data  (i_fill_data),
`ifdef CLUT_CACHE_STATS_EN
    .o_hit_cnt    (o_hit_cnt),
    .o_miss_cnt   (o_miss_cnt),
`endif
    .o_busy       (o_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_once();
    i_fill_ack = 1'b1;
    tick();
    i_fill_ack = 1'b0;
  endtask

  // Beat k carries colours base+2k (low half) and base+2k+1 (high half).
  task automatic send_beats(input logic [15:0] base, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      i_fill_valid = 1'b1;
      i_fill_data  = {base + 16'(2*k + 1), base + 16'(2*k)};
      tick();
    end
    i_fill_valid = 1'b0;
    i_fill_data  = '0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_clut_id = 15'h0100; i_req = 2'b00; i_idx = '0;
    i_fill_ack = 1'b0; i_fill_valid = 1'b0; i_fill_data = '0;
    tick(); tick();
    vecs++; if (o_fill_req !== 1'b0)    begin errs++; $display("FAIL reset_fill_req: got %b want 0", o_fill_req); end
    vecs++; if (o_busy !== 1'b0)        begin errs++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    vecs++; if (o_fill_blk !== 4'h0)    begin errs++; $display("FAIL reset_fill_blk: got %h want 0", o_fill_blk); end
    vecs++; if (o_fill_clut !== 15'h0)  begin errs++; $display("FAIL reset_fill_clut: got %h want 0", o_fill_clut); end
    vecs++; if (o_color !== 32'h0)      begin errs++; $display("FAIL reset_color: got %h want 0", o_color); end
    i_rst = 1'b0;
    tick();
    i_req = 2'b11; #1;
    vecs++; if (o_hit !== 2'b00)        begin errs++; $display("FAIL reset_hit: got %b want 00", o_hit); end
    i_req = 2'b00;
  endtask

  task automatic test_cold_miss();
    i_req = 2'b01; i_idx = {8'h00, 8'h25}; #1;
    vecs++; if (o_miss !== 2'b01 || o_hit !== 2'b00) begin errs++; $display("FAIL cold_lookup: got miss=%b hit=%b want miss=01 hit=00", o_miss, o_hit); end
    tick();
    vecs++; if (o_fill_req !== 1'b1 || o_busy !== 1'b1) begin errs++; $display("FAIL cold_req: got req=%b busy=%b want 1 1", o_fill_req, o_busy); end
    vecs++; if (o_fill_blk !== 4'h2)        begin errs++; $display("FAIL cold_blk: got %h want 2", o_fill_blk); end
    vecs++; if (o_fill_clut !== 15'h0100)   begin errs++; $display("FAIL cold_clut: got %h want 0100", o_fill_clut); end
    ack_once();
    vecs++; if (o_fill_req !== 1'b0 || o_busy !== 1'b1) begin errs++; $display("FAIL cold_ack: got req=%b busy=%b want 0 1", o_fill_req, o_busy); end
    send_beats(16'h0000, 0, 4);
    vecs++; if (o_miss !== 2'b01 || o_hit !== 2'b00) begin errs++; $display("FAIL partial_invisible: got miss=%b hit=%b want 01 00", o_miss, o_hit); end
    send_beats(16'h0000, 5, 7);
    vecs++; if (o_hit !== 2'b01 || o_miss !== 2'b00 || o_busy !== 1'b0) begin errs++; $display("FAIL cold_done: got hit=%b miss=%b busy=%b want 01 00 0", o_hit, o_miss, o_busy); end
    tick();
    vecs++; if (o_color[15:0] !== 16'h0005) begin errs++; $display("FAIL cold_color: got %h want 0005", o_color[15:0]); end
    i_idx = {8'h2F, 8'h24};
    tick();
    vecs++; if (o_color !== {16'h000F, 16'h0004}) begin errs++; $display("FAIL cold_color_ports: got %h want 000f0004", o_color); end
  endtask

  task automatic test_dual_miss();
    i_req = 2'b11; i_idx = {8'h30, 8'h10}; #1;
    vecs++; if (o_miss !== 2'b11) begin errs++; $display("FAIL dual_lookup: got miss=%b want 11", o_miss); end
    tick();
    vecs++; if (o_fill_blk !== 4'h1) begin errs++; $display("FAIL dual_first_blk: got %h want 1", o_fill_blk); end
    ack_once();
    send_beats(16'h0100, 0, 7);
    vecs++; if (o_hit !== 2'b01 || o_miss !== 2'b10) begin errs++; $display("FAIL dual_mid: got hit=%b miss=%b want 01 10", o_hit, o_miss); end
    tick();
    vecs++; if (o_fill_req !== 1'b1 || o_fill_blk !== 4'h3) begin errs++; $display("FAIL dual_second_req: got req=%b blk=%h want 1 3", o_fill_req, o_fill_blk); end
    ack_once();
    send_beats(16'h0300, 0, 7);
    vecs++; if (o_hit !== 2'b11 || o_miss !== 2'b00) begin errs++; $display("FAIL dual_done: got hit=%b miss=%b want 11 00", o_hit, o_miss); end
    i_idx = {8'h3A, 8'h13};
    tick();
    vecs++; if (o_color !== {16'h030A, 16'h0103}) begin errs++; $display("FAIL dual_color: got %h want 030a0103", o_color); end
  endtask

  task automatic test_shared_block();
    i_req = 2'b11; i_idx = {8'h4F, 8'h40}; #1;
    vecs++; if (o_miss !== 2'b11) begin errs++; $display("FAIL shared_lookup: got miss=%b want 11", o_miss); end
    tick();
    vecs++; if (o_fill_blk !== 4'h4) begin errs++; $display("FAIL shared_blk: got %h want 4", o_fill_blk); end
    ack_once();
    send_beats(16'h0400, 0, 7);
    vecs++; if (o_hit !== 2'b11) begin errs++; $display("FAIL shared_hit: got hit=%b want 11", o_hit); end
    tick();
    vecs++; if (o_fill_req !== 1'b0 || o_busy !== 1'b0) begin errs++; $display("FAIL shared_single_fill: got req=%b busy=%b want 0 0", o_fill_req, o_busy); end
    vecs++; if (o_color !== {16'h040F, 16'h0400}) begin errs++; $display("FAIL shared_color: got %h want 040f0400", o_color); end
  endtask

  task automatic test_clut_change();
    i_req = 2'b01; i_idx = {8'h00, 8'h55};
    tick();
    vecs++; if (o_fill_blk !== 4'h5 || o_fill_clut !== 15'h0100) begin errs++; $display("FAIL change_req: got blk=%h clut=%h want 5 0100", o_fill_blk, o_fill_clut); end
    ack_once();
    send_beats(16'h0500, 0, 3);
    i_clut_id = 15'h0140;
    send_beats(16'h0500, 4, 7);
    vecs++; if (o_busy !== 1'b0 || o_miss !== 2'b01 || o_hit !== 2'b00) begin errs++; $display("FAIL change_block_invalid: got busy=%b miss=%b hit=%b want 0 01 00", o_busy, o_miss, o_hit); end
    i_req = 2'b11; i_idx = {8'h25, 8'h55}; #1;
    vecs++; if (o_miss !== 2'b11) begin errs++; $display("FAIL change_all_invalid: got miss=%b want 11", o_miss); end
    tick();
    vecs++; if (o_fill_req !== 1'b1 || o_fill_blk !== 4'h5 || o_fill_clut !== 15'h0140) begin errs++; $display("FAIL change_new_req: got req=%b blk=%h clut=%h want 1 5 0140", o_fill_req, o_fill_blk, o_fill_clut); end
  endtask

  task automatic test_reset_mid_fill();
    ack_once();
    send_beats(16'h0A00, 0, 5);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; i_req = 2'b00;
    vecs++; if (o_fill_req !== 1'b0 || o_busy !== 1'b0) begin errs++; $display("FAIL rst_mid_fill: got req=%b busy=%b want 0 0", o_fill_req, o_busy); end
    send_beats(16'hEE00, 6, 7);
    vecs++; if (o_busy !== 1'b0 || o_fill_req !== 1'b0) begin errs++; $display("FAIL rst_stray_beats: got busy=%b req=%b want 0 0", o_busy, o_fill_req); end
    i_req = 2'b11; i_idx = {8'h5E, 8'h55}; #1;
    vecs++; if (o_miss !== 2'b11 || o_hit !== 2'b00) begin errs++; $display("FAIL rst_all_miss: got miss=%b hit=%b want 11 00", o_miss, o_hit); end
    tick();
    // Storage survives reset: word 5.2 from the interrupted fill, word 5.7 from the aborted one.
    vecs++; if (o_color !== {16'h050E, 16'h0A05}) begin errs++; $display("FAIL rst_storage_kept: got %h want 050e0a05", o_color); end
    i_req = 2'b00;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
  endtask

`ifdef CLUT_CACHE_STATS_EN
  task automatic test_stats();
    i_rst = 1'b1; i_req = 2'b00; i_idx = '0;
    tick();
    i_rst = 1'b0;
    vecs++; if (o_hit_cnt !== 16'h0 || o_miss_cnt !== 16'h0) begin errs++; $display("FAIL stats_reset: got hit=%h miss=%h want 0 0", o_hit_cnt, o_miss_cnt); end
    i_req = 2'b01;
    tick();
    i_req = 2'b00;
    ack_once();
    send_beats(16'h0000, 0, 7);
    i_req = 2'b11;
    repeat (10) tick();
    vecs++; if (o_hit_cnt !== 16'd20 || o_miss_cnt !== 16'd1) begin errs++; $display("FAIL stats_count: got hit=%0d miss=%0d want 20 1", o_hit_cnt, o_miss_cnt); end
    repeat (35000) tick();
    vecs++; if (o_hit_cnt !== 16'hFFFF) begin errs++; $display("FAIL stats_saturate: got %h want ffff", o_hit_cnt); end
    i_req = 2'b00;
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_dual_miss();
    test_shared_block();
    test_clut_change();
    test_reset_mid_fill();
`ifdef CLUT_CACHE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
